// File: rtl/multdiv_sequencer_if.sv
// Request/step-counter/status bundle between the multdiv datapath and its control sequencer.
interface multdiv_sequencer_if #(
    parameter int unsigned CNT_W = 3
);
    logic             ctrl_mult;
    logic             ctrl_div;
    logic             divisor_zero;
    logic [CNT_W-1:0] count_in;
    logic             clear_count;
    logic             step_en;
    logic [CNT_W-1:0] step_idx;
    logic             op_is_div;
    logic             busy;
    logic             result_ready;
    logic             data_exception;
    logic             count_mismatch;

    modport master (
        output ctrl_mult, ctrl_div, divisor_zero, count_in,
        input  clear_count, step_en, step_idx, op_is_div, busy,
               result_ready, data_exception, count_mismatch
    );

    modport slave (
        input  ctrl_mult, ctrl_div, divisor_zero, count_in,
        output clear_count, step_en, step_idx, op_is_div, busy,
               result_ready, data_exception, count_mismatch
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Control FSM for the iterative multiplier/divider: launches a fixed number of steps,
// flags divide-by-zero/illegal requests and cross-checks the external step counter.
module multdiv_sequencer #(
    parameter int unsigned CNT_W     = 3,
    parameter int unsigned LAST_STEP = 7
) (
    input  logic               clock,
    input  logic               reset_n,
    multdiv_sequencer_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             op_is_div_q, op_is_div_d;
    logic             result_ready_q, result_ready_d;
    logic             data_exception_q, data_exception_d;
    logic             count_mismatch_q, count_mismatch_d;

    logic start, illegal, dz, exc_req;

    assign start   = bus.ctrl_mult | bus.ctrl_div;
    assign illegal = bus.ctrl_mult & bus.ctrl_div;
    assign dz      = bus.ctrl_div & ~bus.ctrl_mult & bus.divisor_zero;
    assign exc_req = illegal | dz;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            shadow_q         <= '0;
            op_is_div_q      <= 1'b0;
            result_ready_q   <= 1'b0;
            data_exception_q <= 1'b0;
            count_mismatch_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            shadow_q         <= shadow_d;
            op_is_div_q      <= op_is_div_d;
            result_ready_q   <= result_ready_d;
            data_exception_q <= data_exception_d;
            count_mismatch_q <= count_mismatch_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        shadow_d         = shadow_q;
        op_is_div_d      = op_is_div_q;
        data_exception_d = 1'b0;
        count_mismatch_d = count_mismatch_q;

        case (state_q)
            IDLE: state_d = IDLE;
            RUN: begin
                if (bus.count_in != shadow_q) begin
                    count_mismatch_d = 1'b1;
                end
                if (shadow_q == LAST) begin
                    state_d = DONE;
                end else begin
                    shadow_d = shadow_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A start is honoured in every state and overrides the normal progression.
        if (start) begin
            op_is_div_d = bus.ctrl_div;
            if (exc_req) begin
                state_d          = DONE;
                data_exception_d = 1'b1;
            end else begin
                state_d          = RUN;
                shadow_d         = '0;
                count_mismatch_d = 1'b0;
            end
        end

        result_ready_d = (state_d == DONE);
    end

    // Counter restart is combinational from start so the counter reads 0 on the first RUN cycle.
    assign bus.clear_count    = (state_q != RUN) | start;
    assign bus.step_en        = (state_q == RUN);
    assign bus.busy           = (state_q == RUN);
    assign bus.step_idx       = (state_q == RUN) ? bus.count_in : '0;
    assign bus.op_is_div      = op_is_div_q;
    assign bus.result_ready   = result_ready_q;
    assign bus.data_exception = data_exception_q;
    assign bus.count_mismatch = count_mismatch_q;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer with a 3-bit step-counter model that can inject a skip.
module tb_multdiv_sequencer;
    logic clock;
    logic reset_n;
    logic skip_en;
    logic [2:0] cnt;
    int tests;
    int fails;

    multdiv_sequencer_if #(.CNT_W(3)) bus ();

    multdiv_sequencer #(.CNT_W(3), .LAST_STEP(7)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)                   cnt <= 3'd0;
        else if (bus.clear_count)       cnt <= 3'd0;
        else if (skip_en && cnt == 3'd2) cnt <= 3'd4;
        else                            cnt <= cnt + 3'd1;
    end
    assign bus.count_in = cnt;

    typedef struct {
        logic       m, d, z;
        logic       clr, en;
        logic [2:0] idx;
        logic       busy, rr, exc, opd, mm;
    } row_t;

    row_t rows [17];

    function automatic row_t mk(input logic m, d, z, clr, en, input logic [2:0] idx,
                                input logic busy, rr, exc, opd, mm);
        row_t r;
        r.m = m; r.d = d; r.z = z; r.clr = clr; r.en = en; r.idx = idx;
        r.busy = busy; r.rr = rr; r.exc = exc; r.opd = opd; r.mm = mm;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive request inputs just after the edge, then sample at the falling edge.
    task automatic cyc(input logic m, d, z);
        @(posedge clock);
        #1;
        bus.ctrl_mult    = m;
        bus.ctrl_div     = d;
        bus.divisor_zero = z;
        @(negedge clock);
    endtask

    task automatic check_row(input int i, input row_t r);
        chk($sformatf("row%0d clear_count", i), int'(bus.clear_count), int'(r.clr));
        chk($sformatf("row%0d step_en", i), int'(bus.step_en), int'(r.en));
        chk($sformatf("row%0d step_idx", i), int'(bus.step_idx), int'(r.idx));
        chk($sformatf("row%0d busy", i), int'(bus.busy), int'(r.busy));
        chk($sformatf("row%0d result_ready", i), int'(bus.result_ready), int'(r.rr));
        chk($sformatf("row%0d data_exception", i), int'(bus.data_exception), int'(r.exc));
        chk($sformatf("row%0d op_is_div", i), int'(bus.op_is_div), int'(r.opd));
        chk($sformatf("row%0d count_mismatch", i), int'(bus.count_mismatch), int'(r.mm));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " clear_count"}, int'(bus.clear_count), 1);
        chk({tag, " step_en"}, int'(bus.step_en), 0);
        chk({tag, " step_idx"}, int'(bus.step_idx), 0);
        chk({tag, " busy"}, int'(bus.busy), 0);
        chk({tag, " result_ready"}, int'(bus.result_ready), 0);
        chk({tag, " data_exception"}, int'(bus.data_exception), 0);
        chk({tag, " op_is_div"}, int'(bus.op_is_div), 0);
        chk({tag, " count_mismatch"}, int'(bus.count_mismatch), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        skip_en = 1'b0;
        reset_n = 1'b0;
        bus.ctrl_mult = 1'b0;
        bus.ctrl_div = 1'b0;
        bus.divisor_zero = 1'b0;

        // Legal multiply: T0 request, RUN T1..T8, result at T9.
        rows[0] = mk(1, 0, 0, 1, 0, 3'd0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++)
            rows[k] = mk(0, 0, 0, 0, 1, 3'(k - 1), 1, 0, 0, 0, 0);
        rows[9]  = mk(0, 0, 0, 1, 0, 3'd0, 0, 1, 0, 0, 0);
        rows[10] = mk(0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 0, 0);
        // Divide by zero: exception at T1, never RUN.
        rows[11] = mk(0, 1, 1, 1, 0, 3'd0, 0, 0, 0, 0, 0);
        rows[12] = mk(0, 0, 0, 1, 0, 3'd0, 0, 1, 1, 1, 0);
        rows[13] = mk(0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 1, 0);
        // Illegal mult+div: exception at T1, IDLE at T2.
        rows[14] = mk(1, 1, 0, 1, 0, 3'd0, 0, 0, 0, 1, 0);
        rows[15] = mk(0, 0, 0, 1, 0, 3'd0, 0, 1, 1, 1, 0);
        rows[16] = mk(0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 1, 0);

        repeat (2) @(negedge clock);
        check_reset_vals("in_reset");
        reset_n = 1'b1;
        repeat (2) cyc(0, 0, 0);

        for (int i = 0; i < 17; i++) begin
            cyc(rows[i].m, rows[i].d, rows[i].z);
            check_row(i, rows[i]);
        end

        // Abort: divide at T0, multiply relaunch at T4, result only at T13.
        cyc(0, 1, 0);
        chk("abort T0 clear_count", int'(bus.clear_count), 1);
        cyc(0, 0, 0);
        chk("abort T1 op_is_div", int'(bus.op_is_div), 1);
        chk("abort T1 busy", int'(bus.busy), 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("abort T4 step_idx", int'(bus.step_idx), 3);
        chk("abort T4 clear_count", int'(bus.clear_count), 1);
        cyc(0, 0, 0);
        chk("abort T5 step_idx", int'(bus.step_idx), 0);
        chk("abort T5 op_is_div", int'(bus.op_is_div), 0);
        chk("abort T5 busy", int'(bus.busy), 1);
        for (int c = 6; c <= 13; c++) begin
            cyc(0, 0, 0);
            chk($sformatf("abort T%0d result_ready", c), int'(bus.result_ready), (c == 13) ? 1 : 0);
        end
        chk("abort T13 data_exception", int'(bus.data_exception), 0);
        cyc(0, 0, 0);

        // Counter skips 2 -> 4: mismatch sticky through DONE/IDLE, cleared on next legal start.
        skip_en = 1'b1;
        cyc(1, 0, 0);
        for (int c = 1; c <= 10; c++) begin
            cyc(0, 0, 0);
            chk($sformatf("skip T%0d count_mismatch", c), int'(bus.count_mismatch), (c >= 5) ? 1 : 0);
            if (c == 4) chk("skip T4 step_idx", int'(bus.step_idx), 4);
            if (c == 9) chk("skip T9 result_ready", int'(bus.result_ready), 1);
        end
        skip_en = 1'b0;
        cyc(1, 0, 0);
        chk("relaunch T0 count_mismatch", int'(bus.count_mismatch), 1);
        cyc(0, 0, 0);
        chk("relaunch T1 count_mismatch", int'(bus.count_mismatch), 0);
        repeat (10) cyc(0, 0, 0);

        // Reset mid-RUN at T5 of a multiply.
        cyc(1, 0, 0);
        for (int c = 1; c <= 5; c++) cyc(0, 0, 0);
        chk("rst T5 busy", int'(bus.busy), 1);
        chk("rst T5 step_idx", int'(bus.step_idx), 4);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("async_reset");
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_vals("held_reset");
        reset_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 12; c++) begin
                cyc(0, 0, 0);
                if (bus.result_ready) seen++;
            end
            chk("post_reset result_ready pulses", seen, 0);
        end
        cyc(1, 0, 0);
        for (int c = 1; c <= 9; c++) begin
            cyc(0, 0, 0);
            chk($sformatf("post_reset mult T%0d result_ready", c), int'(bus.result_ready), (c == 9) ? 1 : 0);
        end
        chk("post_reset mult data_exception", int'(bus.data_exception), 0);
        chk("post_reset mult count_mismatch", int'(bus.count_mismatch), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Control FSM for the iterative multiplier/divider. It drives the restart input of the 3-bit step counter in multdiv and consumes that counter's count value.
- It accepts a one-cycle multiply or divide request and enables the datapath for a fixed number of steps.
- It flags divide-by-zero and illegal requests, then raises a one-cycle result_ready.
- A shadow counter cross-checks the external step counter on every RUN cycle.

Parameters:
- CNT_W, 3, width of the step count bus.
- LAST_STEP, 7, final step index. The number of steps is LAST_STEP+1. LAST_STEP must be ≤ 2^CNT_W − 1.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  reset; asynchronous, active-low.
- ctrl_mult  input  1  one-cycle multiply request.
- ctrl_div  input  1  one-cycle divide request.
- divisor_zero  input  1  divisor is zero; sampled only with ctrl_div.
- count_in  input  CNT_W  current value of the external step counter.
- clear_count  output  1  restart to the step counter; high holds or forces the counter to 0 at the next edge.
- step_en  output  1  datapath performs one iteration this cycle.
- step_idx  output  CNT_W  iteration index for the datapath; equals count_in while in RUN.
- op_is_div  output  1  latched operation: 1 = divide, 0 = multiply.
- busy  output  1  high in RUN.
- result_ready  output  1  one-cycle pulse marking the result valid.
- data_exception  output  1  valid with result_ready: divide-by-zero or illegal request.
- count_mismatch  output  1  sticky: count_in differed from the shadow count during RUN.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - reset_n low asynchronously forces the state to IDLE and clears the shadow count, op_is_div, result_ready, data_exception and count_mismatch.
  - While in reset, outputs are: clear_count=1, step_en=0, step_idx=0, busy=0.
- Request decode:
  - start = ctrl_mult | ctrl_div.
  - illegal = ctrl_mult & ctrl_div.
  - dz = ctrl_div & ~ctrl_mult & divisor_zero.
- States are IDLE, RUN and DONE, held in registered state bits.
- IDLE:
  - No start: stay in IDLE.
  - start & (illegal | dz): go to DONE. At the edge, data_exception ← 1 and op_is_div ← ctrl_div.
  - start otherwise: go to RUN. At the edge, op_is_div ← ctrl_div, shadow count ← 0, count_mismatch ← 0.
- RUN:
  - Outputs: step_en=1, busy=1, step_idx=count_in.
  - Each cycle, compare count_in with the shadow count. If they differ, count_mismatch ← 1 (sticky).
  - The shadow count increments each RUN cycle.
  - When shadow == LAST_STEP and there is no start: go to DONE.
  - A start while in RUN aborts the operation and relaunches it, with the same decode as from IDLE. A legal start goes to RUN with the shadow count ← 0; an illegal or dz start goes to DONE with data_exception ← 1.
- DONE:
  - result_ready=1 for exactly one cycle, then go to IDLE.
  - data_exception holds its latched value during DONE and clears on leaving DONE.
  - A start in DONE is taken with the same decode as from IDLE; result_ready still pulses that cycle.
- clear_count = (state != RUN) | start. It is combinational from start so that the counter reads 0 in the first RUN cycle.
- Latency for a legal request at cycle T0:
  - RUN occupies T1 through T(LAST_STEP+1).
  - result_ready is high at T(LAST_STEP+2), which is T9 at the defaults.
- Latency for an exception request: result_ready and data_exception are high at T1.
- step_idx=0 outside RUN.
- The shadow count stops at LAST_STEP and does not wrap.
- count_mismatch is unaffected by DONE/IDLE and clears only on a legal start or on reset.
- A reset asserted mid-RUN abandons the operation; no result_ready pulse follows.

Test Plan:
- ctrl_mult pulse at T0 with a conforming counter model: step_en high T1–T8, step_idx 0..7, result_ready=1 and data_exception=0 only at T9, op_is_div=0, count_mismatch=0.
- ctrl_div with divisor_zero=1 at T0: no RUN cycle; result_ready=1, data_exception=1, op_is_div=1 at T1; clear_count=1 throughout.
- ctrl_mult and ctrl_div both high at T0: result_ready=1 and data_exception=1 at T1; IDLE at T2.
- ctrl_div at T0, then ctrl_mult at T4 (step 3): clear_count=1 at T4, step_idx=0 at T5, op_is_div=0, result_ready at T13, no pulse at T9.
- Counter model skips from 2 to 4 during RUN: count_mismatch goes to 1 on the first wrong cycle and stays 1 through DONE/IDLE; it clears on the next legal start.
- reset_n driven low at T5 of a multiply: outputs go to their reset values immediately (asynchronously); no result_ready afterwards; a new ctrl_mult after release completes normally.
